// File: rtl/pc_gen_pkg.sv
// Shared pc-select encodings and next-pc decision types for the fetch PC generator.
// No logic of its own; the instruction decoder imports the same SEL_PC_* values.
// Optional trap support in the consumers is enabled with PC_GEN_TRAP_EN.
package pc_gen_pkg;

    // pc-select encodings; the decoder drives these onto pc_sel.
    localparam int SEL_PC_WIDTH = 2;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_NONE = 2'd0;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4 = 2'd1;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JAL  = 2'd2;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR = 2'd3;

    // Which source feeds the pc register at the next edge, in priority order
    // from highest (trap) to lowest (normal target).
    typedef enum logic [2:0] {
        NXT_TARGET = 3'd0,  // accept candidate from pc_target
        NXT_REJECT = 3'd1,  // taken jump to a non-word-aligned target: hold
        NXT_HOLD   = 3'd2,  // stall: hold
        NXT_MRET   = 3'd3,  // return to saved exception pc
        NXT_TRAP   = 3'd4   // enter trap vector
    } nxt_src_e;

    // True for the selects whose target depends on the taken flag.
    function automatic logic sel_is_jump(input logic [SEL_PC_WIDTH-1:0] sel);
        return (sel == SEL_PC_JAL) || (sel == SEL_PC_JALR);
    endfunction

endpackage

// File: rtl/pc_target.sv
// Combinational candidate next-pc and misalignment check for the selected pc source.
// Latency: zero (pure combinational); pc_gen registers the result.
// No flow control; the owner decides whether the candidate is used.
module pc_target
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]         i_pc,
    input  logic [SEL_PC_WIDTH-1:0] i_pc_sel,
    input  logic                    i_taken,
    input  logic [XLEN-1:0]         i_rs1,
    input  logic [XLEN-1:0]         i_imm,
    output logic [XLEN-1:0]         o_target,
    output logic                    o_jump,
    output logic                    o_misalign
);

    localparam logic [XLEN-1:0] C_FOUR      = XLEN'(4);
    localparam logic [XLEN-1:0] C_BIT0_MASK = ~XLEN'(1);

    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_jal;
    logic [XLEN-1:0] w_jalr;

    // All three adders run in parallel; sums wrap naturally at 2^XLEN.
    always_comb begin
        w_seq  = i_pc + C_FOUR;
        w_jal  = i_pc + i_imm;
        w_jalr = (i_rs1 + i_imm) & C_BIT0_MASK;
    end

    // Select the candidate; a not-taken jump falls through to pc+4.
    always_comb begin
        o_jump   = i_taken & sel_is_jump(i_pc_sel);
        o_target = i_pc;
        if (o_jump) begin
            o_target = (i_pc_sel == SEL_PC_JAL) ? w_jal : w_jalr;
        end else if (i_pc_sel != SEL_PC_NONE) begin
            o_target = w_seq;
        end
        // Only taken jumps are checked; bit0 is either cleared (JALR) or
        // ignored, bit1 set means the target is not on a word boundary.
        o_misalign = o_jump & o_target[1];
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: registered pc with sequential, jump, stall, trap and mret update.
// Latency: one clock from select inputs to pc; next_pc shows the decision in the same cycle.
// stall holds pc; trap/mret handling compiled in only with `define PC_GEN_TRAP_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [SEL_PC_WIDTH-1:0] pc_sel,
    input  logic                    taken,
    input  logic [XLEN-1:0]         rs1,
    input  logic [XLEN-1:0]         imm,
    input  logic                    trap,
    input  logic                    mret,
    input  logic [XLEN-1:0]         tvec,
    output logic [XLEN-1:0]         pc,
    output logic [XLEN-1:0]         next_pc,
    output logic [XLEN-1:0]         epc,
    output logic                    redirect,
    output logic                    misalign,
    output logic [XLEN-1:0]         misalign_addr
);

    localparam logic [XLEN-1:0] C_WORD_MASK = ~XLEN'(3);

    logic [XLEN-1:0] r_pc;
    logic            r_redirect;
    logic            r_misalign;
    logic [XLEN-1:0] r_misalign_addr;

    logic [XLEN-1:0] w_target;
    logic            w_jump;
    logic            w_reject;
    logic            w_trap;
    logic            w_mret;
    logic [XLEN-1:0] w_tvec_base;
    logic [XLEN-1:0] w_epc;
    nxt_src_e        w_src;
    logic [XLEN-1:0] w_next_pc;
    logic            w_redirect_nxt;
    logic            w_misalign_nxt;

    pc_target #(
        .XLEN (XLEN)
    ) u_target (
        .i_pc       (r_pc),
        .i_pc_sel   (pc_sel),
        .i_taken    (taken),
        .i_rs1      (rs1),
        .i_imm      (imm),
        .o_target   (w_target),
        .o_jump     (w_jump),
        .o_misalign (w_reject)
    );

`ifdef PC_GEN_TRAP_EN
    logic [XLEN-1:0] r_epc;

    assign w_trap      = trap;
    assign w_mret      = mret;
    assign w_tvec_base = tvec & C_WORD_MASK;
    assign w_epc       = r_epc;

    // Capture the interrupted pc on trap entry; mret only reads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc <= '0;
        end else if (w_src == NXT_TRAP) begin
            r_epc <= r_pc;
        end
    end
`else
    // Trap inputs are tied off in this build; reduce them so they are not dangling.
    logic w_unused_trap;

    assign w_unused_trap = ^{trap, mret, tvec};
    assign w_trap        = 1'b0;
    assign w_mret        = 1'b0;
    assign w_tvec_base   = '0;
    assign w_epc         = '0;
`endif

    // Priority: trap over mret over stall over the selected target.
    // trap and mret together resolve as trap because trap is tested first.
    always_comb begin
        w_src = NXT_TARGET;
        if (w_trap) begin
            w_src = NXT_TRAP;
        end else if (w_mret) begin
            w_src = NXT_MRET;
        end else if (stall) begin
            w_src = NXT_HOLD;
        end else if (w_reject) begin
            w_src = NXT_REJECT;
        end
    end

    // Map the chosen source to next pc and the flags registered alongside it.
    always_comb begin
        w_next_pc      = w_target;
        w_redirect_nxt = w_jump;
        w_misalign_nxt = 1'b0;
        unique case (w_src)
            NXT_TRAP: begin
                w_next_pc      = w_tvec_base;
                w_redirect_nxt = 1'b1;
            end
            NXT_MRET: begin
                w_next_pc      = w_epc;
                w_redirect_nxt = 1'b1;
            end
            NXT_HOLD: begin
                w_next_pc      = r_pc;
                w_redirect_nxt = 1'b0;
            end
            NXT_REJECT: begin
                w_next_pc      = r_pc;
                w_redirect_nxt = 1'b0;
                w_misalign_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // pc and status flags; misalign is a one-cycle pulse, its address is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_VECTOR;
            r_redirect      <= 1'b0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_pc       <= w_next_pc;
            r_redirect <= w_redirect_nxt;
            r_misalign <= w_misalign_nxt;
            if (w_misalign_nxt) begin
                r_misalign_addr <= w_target;
            end
        end
    end

    assign pc            = r_pc;
    assign next_pc       = w_next_pc;
    assign epc           = w_epc;
    assign redirect      = r_redirect;
    assign misalign      = r_misalign;
    assign misalign_addr = r_misalign_addr;

endmodule
